ex_mem_buf: RTL and testbench
=============================

EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 SHALL provide port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide in_valid input 1 and in_ready output 1: upstream ALU-stage beat handshake.
REQ-004 SHALL provide alu_result input 64 and store_data input 64: ALU result and store operand.
REQ-005 SHALL provide alu_negative, alu_zero, alu_overflow, alu_carry, inputs, 1 each: ALU flags for the beat.
REQ-006 SHALL provide set_flags input 1: beat updates the NZVC register (ADDS/SUBS).
REQ-007 SHALL provide rd input 5, reg_write input 1, mem_read input 1, mem_write input 1: destination and control.
REQ-008 SHALL provide br_cond input 1 (B.cond), br_cbz input 1 (CBZ), cond input 4 (ARM condition code).
REQ-009 SHALL provide flush input 1: discard all buffered and incoming beats.
REQ-010 SHALL provide out_valid output 1 and out_ready input 1: downstream memory-stage handshake.
REQ-011 SHALL provide out_result 64, out_store_data 64, out_rd 5, out_reg_write 1, out_mem_read 1, out_mem_write 1, out_branch_taken 1, outputs: head-entry fields.
REQ-012 SHALL provide flags output 4: architectural {N,Z,V,C} register.

Function
REQ-013 SHALL buffer up to two beats in FIFO order; occupancy states EMPTY, ONE, TWO.
REQ-014 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in TWO.
REQ-015 Accept SHALL occur when in_valid and in_ready; pop SHALL occur when out_valid and out_ready.
REQ-016 out_valid SHALL be 1 in ONE and TWO; head-entry fields SHALL remain stable while out_valid and not out_ready.
REQ-017 Transitions: EMPTY+accept->ONE; ONE+accept+pop->ONE; ONE+accept only->TWO; ONE+pop only->EMPTY; TWO+pop->ONE; otherwise hold.
REQ-018 Latency SHALL be one cycle: a beat accepted into EMPTY appears on out_* the following cycle.
REQ-019 On accept with set_flags=1, flags SHALL load {alu_negative,alu_zero,alu_overflow,alu_carry} at that edge, in accept order.
REQ-020 Branch decision SHALL be computed at accept and stored with the entry; B.cond SHALL use flags value before this beat's own update.
REQ-021 cond decode: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 111x true.
REQ-022 out_branch_taken SHALL equal (br_cond & cond_true) | (br_cbz & alu_zero); 0 when neither set; br_cond and br_cbz both set SHALL be treated as br_cbz.
REQ-023 flush SHALL take priority over accept and pop: next state EMPTY, in_ready=1 next cycle, incoming beat discarded without flag update.
REQ-024 flush SHALL NOT roll back flags already updated by previously accepted beats.
REQ-025 Accept attempted while in_ready=0 SHALL have no effect on state or flags.

Reset
REQ-026 reset SHALL immediately force state EMPTY, out_valid=0, in_ready=1, flags=4'b0000, all out_* data fields zero.
REQ-027 Reset asserted mid-operation SHALL discard both entries; first accept after deassertion SHALL behave as from EMPTY.

Verification
REQ-028 Reset, then accept alu_result=64'h5, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3; cycle after, out_valid=0.
REQ-029 out_ready=0, accept three back-to-back beats 1,2,3 -> in_ready=0 after second accept, beat 3 held off; raise out_ready -> outputs 1,2,3 in order, no loss or duplication.
REQ-030 Accept SUBS with alu_zero=1,set_flags=1, then B.cond cond=0000 -> flags=4'b0100 after first edge, second entry out_branch_taken=1; same beat pair with cond=0001 -> 0.
REQ-031 Single beat with set_flags=1 (N=1) and br_cond=1, cond=0100, prior flags 0 -> out_branch_taken=0, flags=4'b1000 afterwards.
REQ-032 In TWO, assert flush with in_valid=1 and set_flags=1 -> next cycle out_valid=0, in_ready=1, flags unchanged.
REQ-033 Assert reset asynchronously between edges while in ONE -> out_valid=0, flags=0 before next clock edge.

Source files
------------

// File: rtl/ex_mem_buf.sv
// rtl/ex_mem_buf.sv - two-entry EX/MEM skid buffer with NZVC flags and branch resolve
module ex_mem_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        set_flags,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        br_cond,
  input  logic        br_cbz,
  input  logic [3:0]  cond,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [63:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_branch_taken,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_taken;
  } entry_t;

  state_t     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  entry_t     head_q, tail_q;
  entry_t     new_entry;
  logic [3:0] flags_q;
  logic       accept, pop;
  logic       cond_true;

  // Flags before this beat's own update: N=3, Z=2, V=1, C=0
  always_comb begin
    cond_true = 1'b0;
    case (cond[3:1])
      3'b000: cond_true = flags_q[2];
      3'b001: cond_true = flags_q[0];
      3'b010: cond_true = flags_q[3];
      3'b011: cond_true = flags_q[1];
      3'b100: cond_true = flags_q[0] & ~flags_q[2];
      3'b101: cond_true = flags_q[3] == flags_q[1];
      3'b110: cond_true = ~flags_q[2] & (flags_q[3] == flags_q[1]);
      default: cond_true = 1'b1;
    endcase
    // Odd codes invert the base condition, except 111x which is always true
    if (cond[0] && cond[3:1] != 3'b111) begin
      cond_true = ~cond_true;
    end
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // Capture the incoming beat with its branch decision resolved now; CBZ wins over B.cond
  always_comb begin
    new_entry.result     = alu_result;
    new_entry.store_data = store_data;
    new_entry.rd         = rd;
    new_entry.reg_write  = reg_write;
    new_entry.mem_read   = mem_read;
    new_entry.mem_write  = mem_write;
    if (br_cbz) begin
      new_entry.branch_taken = alu_zero;
    end else if (br_cond) begin
      new_entry.branch_taken = cond_true;
    end else begin
      new_entry.branch_taken = 1'b0;
    end
  end

  // Occupancy state and registered in_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next occupancy; flush overrides both accept and pop
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = S_ONE;
        S_ONE: begin
          if (accept && !pop) begin
            state_d = S_TWO;
          end else if (!accept && pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Handshake outputs derived from occupancy
  always_comb begin
    out_valid  = (state_q != S_EMPTY);
    in_ready_d = (state_d != S_TWO);
  end

  // Entry storage: head is always the oldest beat, tail shifts forward on pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      case (state_q)
        S_EMPTY: if (accept) head_q <= new_entry;
        S_ONE: begin
          if (accept && pop) begin
            head_q <= new_entry;
          end else if (accept) begin
            tail_q <= new_entry;
          end
        end
        S_TWO: if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // Architectural NZVC updates in accept order; flush never rolls it back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (accept && set_flags && !flush) begin
      flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry};
    end
  end

  assign in_ready         = in_ready_q;
  assign flags            = flags_q;
  assign out_result       = head_q.result;
  assign out_store_data   = head_q.store_data;
  assign out_rd           = head_q.rd;
  assign out_reg_write    = head_q.reg_write;
  assign out_mem_read     = head_q.mem_read;
  assign out_mem_write    = head_q.mem_write;
  assign out_branch_taken = head_q.branch_taken;

endmodule

// File: tb/tb_ex_mem_buf.sv
// tb/tb_ex_mem_buf.sv - scoreboard bench for ex_mem_buf
module tb_ex_mem_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] alu_result, store_data;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry;
  logic        set_flags;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic        br_cond, br_cbz;
  logic [3:0]  cond;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch_taken;
  logic [3:0]  flags;

  ex_mem_buf dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .set_flags(set_flags), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .br_cond(br_cond), .br_cbz(br_cbz), .cond(cond), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch_taken(out_branch_taken), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] sd;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Scoreboard: pop on transfer out, push on transfer in
  always @(negedge clk) begin
    exp_t e, got;
    logic bt;
    if (reset) begin
      sb.delete();
      mflags = 4'b0000;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          got.ctrl = {out_rd, out_reg_write, out_mem_read, out_mem_write, out_branch_taken};
          check_eq("sb_result", out_result, e.res);
          check_eq("sb_store", out_store_data, e.sd);
          check_eq("sb_ctrl", {55'd0, got.ctrl}, {55'd0, e.ctrl});
        end
      end
      if (in_valid && in_ready) begin
        if (br_cbz) bt = alu_zero;
        else if (br_cond) bt = cond_ok(mflags, cond);
        else bt = 1'b0;
        e.res  = alu_result;
        e.sd   = store_data;
        e.ctrl = {rd, reg_write, mem_read, mem_write, bt};
        sb.push_back(e);
        if (set_flags) mflags = {alu_negative, alu_zero, alu_overflow, alu_carry};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] res, input logic [4:0] d, input logic setf,
                       input logic [3:0] nzvc, input logic brc, input logic cbz,
                       input logic [3:0] cnd);
    in_valid   = 1'b1;
    alu_result = res;
    store_data = res ^ 64'hA5A5_0000_5A5A_FFFF;
    rd         = d;
    reg_write  = 1'b1;
    mem_read   = res[1];
    mem_write  = res[0];
    set_flags  = setf;
    {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
    br_cond    = brc;
    br_cbz     = cbz;
    cond       = cnd;
  endtask

  initial begin
    bit got3;
    reset = 1'b1; in_valid = 0; alu_result = 0; store_data = 0;
    {alu_negative, alu_zero, alu_overflow, alu_carry} = 4'b0;
    set_flags = 0; rd = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    br_cond = 0; br_cbz = 0; cond = 0; flush = 0; out_ready = 0;
    mflags = 4'b0;
    step(); step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_flags", flags, 0);
    check_eq("rst_out_result", out_result, 0);
    reset = 1'b0;
    step();

    // Single beat, one-cycle latency
    out_ready = 1'b1;
    drive(64'h5, 5'd3, 0, 4'b0, 0, 0, 4'h0);
    step();
    in_valid = 0;
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_result", out_result, 64'h5);
    check_eq("lat_rd", out_rd, 3);
    step();
    check_eq("lat_drain", out_valid, 0);

    // Back-to-back with stalled consumer
    out_ready = 1'b0;
    drive(64'd1, 5'd1, 0, 4'b0, 0, 0, 4'h0);
    step();
    drive(64'd2, 5'd2, 0, 4'b0, 0, 0, 4'h0);
    step();
    check_eq("full_in_ready", in_ready, 0);
    drive(64'd3, 5'd3, 1, 4'b1111, 0, 0, 4'h0);
    step();
    check_eq("full_hold_ready", in_ready, 0);
    check_eq("full_head_stable", out_result, 64'd1);
    check_eq("full_flags_hold", flags, mflags);
    out_ready = 1'b1;
    got3 = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        step();
        got3 = 1;
        break;
      end
      step();
    end
    if (!got3) check_eq("beat3_accept_timeout", 64'd0, 64'd1);
    in_valid = 0;
    step(); step(); step();
    check_eq("b2b_drained", out_valid, 0);
    check_eq("b2b_sb_empty", sb.size(), 0);
    check_eq("b2b_flags", flags, 4'b1111);

    // SUBS sets Z then B.EQ / B.NE
    drive(64'd10, 5'd4, 1, 4'b0100, 0, 0, 4'h0);
    step();
    check_eq("subs_flags", flags, 4'b0100);
    drive(64'd11, 5'd5, 0, 4'b0, 1, 0, 4'h0);
    step();
    in_valid = 0;
    check_eq("beq_taken", out_branch_taken, 1);
    drive(64'd12, 5'd4, 1, 4'b0100, 0, 0, 4'h0);
    step();
    drive(64'd13, 5'd5, 0, 4'b0, 1, 0, 4'h1);
    step();
    in_valid = 0;
    check_eq("bne_not_taken", out_branch_taken, 0);
    step();

    // Reset mid-stream, then B.MI uses flags before own update
    reset = 1'b1; step(); reset = 1'b0; step();
    drive(64'd20, 5'd6, 1, 4'b1000, 1, 0, 4'h4);
    step();
    in_valid = 0;
    check_eq("bmi_old_flags", out_branch_taken, 0);
    check_eq("bmi_flags_after", flags, 4'b1000);
    step();

    // Flush in TWO discards everything, flags untouched
    out_ready = 1'b0;
    drive(64'd30, 5'd7, 0, 4'b0, 0, 0, 4'h0);
    step();
    drive(64'd31, 5'd8, 0, 4'b0, 0, 0, 4'h0);
    step();
    flush = 1'b1;
    drive(64'd32, 5'd9, 1, 4'b0110, 0, 0, 4'h0);
    step();
    flush = 1'b0; in_valid = 0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_in_ready", in_ready, 1);
    check_eq("flush_flags", flags, 4'b1000);

    // Asynchronous reset while in ONE
    out_ready = 1'b0;
    drive(64'd40, 5'd10, 1, 4'b0011, 0, 1, 4'h0);
    step();
    in_valid = 0;
    check_eq("async_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_valid", out_valid, 0);
    check_eq("async_flags", flags, 0);
    check_eq("async_in_ready", in_ready, 1);
    check_eq("async_result", out_result, 0);
    step();
    reset = 1'b0;
    step();
    out_ready = 1'b1;
    drive(64'd50, 5'd11, 0, 4'b0, 0, 0, 4'h0);
    step();
    in_valid = 0;
    check_eq("post_rst_valid", out_valid, 1);
    check_eq("post_rst_result", out_result, 64'd50);
    step();

    // Random traffic across all condition codes and backpressure
    for (int i = 0; i < 200; i++) begin
      drive({$urandom, $urandom}, 5'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if ((i % 25) == 24) check_eq("rand_flags", flags, mflags);
    end
    in_valid  = 0;
    out_ready = 1;
    step(); step(); step();
    check_eq("final_sb_empty", sb.size(), 0);
    check_eq("final_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
